ac97_frame_tx: RTL and testbench



---
 rtl/ac97_pkg.sv | 43 ++++
 rtl/ac97_frame_tx_bit_tick_gen.sv | 34 +++
 rtl/ac97_frame_tx.sv | 109 ++++++++++
 tb/tb_ac97_frame_tx.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ac97_pkg.sv
// rtl/ac97_pkg.sv - AC97 output frame geometry shared by the frame serialiser
//
// Frame positions are counted in serial bits from the frame-start bit (0)
// and every field goes out MSB first.
package ac97_pkg;

    localparam int FRAME_BITS = 256;
    localparam int TAG_BITS   = 16;
    localparam int SLOT_BITS  = 20;

    // First bit of each slot within the frame.
    localparam int SLOT1 = 16;
    localparam int SLOT2 = 36;
    localparam int SLOT3 = 56;
    localparam int SLOT4 = 76;

    // Everything from here to the end of the frame is zero.
    localparam int PAYLOAD_END = SLOT4 + SLOT_BITS;

    // Bit indices inside the 16-bit tag word.
    localparam int TAG_FRAME_VALID = 15;
    localparam int TAG_SLOT1_VALID = 14;
    localparam int TAG_SLOT2_VALID = 13;
    localparam int TAG_SLOT3_VALID = 12;
    localparam int TAG_SLOT4_VALID = 11;

    // Slot 1 bit 19: 0 selects a register write.
    localparam logic CMD_WRITE = 1'b0;

    // PCM slots are always marked valid; command slots only when a
    // command was accepted at this frame start.
    function automatic logic [TAG_BITS-1:0] make_tag(input logic cmd_pend);
        logic [TAG_BITS-1:0] t;
        t                  = '0;
        t[TAG_FRAME_VALID] = 1'b1;
        t[TAG_SLOT1_VALID] = cmd_pend;
        t[TAG_SLOT2_VALID] = cmd_pend;
        t[TAG_SLOT3_VALID] = 1'b1;
        t[TAG_SLOT4_VALID] = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/ac97_frame_tx_bit_tick_gen.sv
// rtl/ac97_frame_tx_bit_tick_gen.sv - serial bit-rate enable from clock_24M
//
// Ports:
//   clock_24M  system clock
//   reset_n    synchronous active-low reset
//   tick       high for one clock every CLK_DIV clocks (CLK_DIV >= 2)
module bit_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clock_24M,
    input  logic reset_n,
    output logic tick
);

    localparam int              CW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clock_24M) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CW'(1);
        end
    end

    // Decoded from the count so the first tick lands CLK_DIV cycles
    // after reset release.
    assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/ac97_frame_tx.sv
// rtl/ac97_frame_tx.sv - AC97 output frame serialiser with register-write slots
//
// Ports:
//   clock_24M              system clock
//   reset_n                synchronous active-low reset
//   pcm_left, pcm_right    PCM samples (DATA_W <= 20), latched at frame start
//   ready                  one-cycle pulse in the frame-start tick cycle
//   cmd_valid/addr/data    pending codec register write
//   cmd_ready              one-cycle acceptance, coincident with ready
//   sdata_out              serial frame data, MSB first, registered
//   sync                   high during the 16 tag bits, registered
module ac97_frame_tx
    import ac97_pkg::*;
#(
    parameter int DATA_W  = 20,
    parameter int CLK_DIV = 2
) (
    input  logic              clock_24M,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] pcm_left,
    input  logic [DATA_W-1:0] pcm_right,
    output logic              ready,
    input  logic              cmd_valid,
    input  logic [6:0]        cmd_addr,
    input  logic [15:0]       cmd_data,
    output logic              cmd_ready,
    output logic              sdata_out,
    output logic              sync
);

    logic                   tick;
    logic                   frame_start;
    logic [7:0]             bit_cnt;
    logic [7:0]             bit_cnt_nxt;

    logic [DATA_W-1:0]      left_sh;
    logic [DATA_W-1:0]      right_sh;
    logic                   cmd_pend;
    logic [6:0]             addr_sh;
    logic [15:0]            data_sh;

    logic [TAG_BITS-1:0]    tag;
    logic [SLOT_BITS-1:0]   slot1;
    logic [SLOT_BITS-1:0]   slot2;
    logic [SLOT_BITS-1:0]   slot3;
    logic [SLOT_BITS-1:0]   slot4;
    logic [PAYLOAD_END-1:0] payload;
    logic                   frame_bit;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_tick_gen (
        .clock_24M (clock_24M),
        .reset_n   (reset_n),
        .tick      (tick)
    );

    assign bit_cnt_nxt = bit_cnt + 8'd1;
    assign frame_start = tick && (bit_cnt == 8'(FRAME_BITS - 1));

    // Combinational so a cmd_valid that rises in the frame-start cycle is
    // acknowledged in that same cycle.
    assign ready     = frame_start;
    assign cmd_ready = frame_start && cmd_valid;

    // Slot mux works from the shadow registers. At the frame-start tick the
    // shadows still hold the previous frame, but the only bit emitted then
    // is tag bit 15 (frame valid), which is constant 1.
    always_comb begin
        tag     = make_tag(cmd_pend);
        slot1   = cmd_pend ? {CMD_WRITE, addr_sh, 12'h000} : '0;
        slot2   = cmd_pend ? {data_sh, 4'h0} : '0;
        slot3   = SLOT_BITS'(left_sh) << (SLOT_BITS - DATA_W);
        slot4   = SLOT_BITS'(right_sh) << (SLOT_BITS - DATA_W);
        payload = {tag, slot1, slot2, slot3, slot4};
        if (bit_cnt_nxt < 8'(PAYLOAD_END)) begin
            frame_bit = payload[7'(8'(PAYLOAD_END - 1) - bit_cnt_nxt)];
        end else begin
            frame_bit = 1'b0;
        end
    end

    always_ff @(posedge clock_24M) begin
        if (!reset_n) begin
            bit_cnt   <= 8'(FRAME_BITS - 1);
            sdata_out <= 1'b0;
            sync      <= 1'b0;
            left_sh   <= '0;
            right_sh  <= '0;
            cmd_pend  <= 1'b0;
            addr_sh   <= '0;
            data_sh   <= '0;
        end else if (tick) begin
            bit_cnt   <= bit_cnt_nxt;
            sdata_out <= frame_bit;
            sync      <= (bit_cnt_nxt < 8'(TAG_BITS));
            if (frame_start) begin
                left_sh  <= pcm_left;
                right_sh <= pcm_right;
                cmd_pend <= cmd_valid;
                if (cmd_valid) begin
                    addr_sh <= cmd_addr;
                    data_sh <= cmd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ac97_frame_tx.sv
// tb/tb_ac97_frame_tx.sv - self-checking bench for ac97_frame_tx
module tb_ac97_frame_tx;

    localparam int CLK_DIV   = 2;
    localparam int FRAME_CYC = 256 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] pcm_left, pcm_right;
    logic        ready, cmd_ready, sdata_out, sync;
    logic        cmd_valid;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;

    logic [19:0] pcm4_left, pcm4_right;
    logic        ready4, cmd_ready4, sdata4, sync4;

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_ready_seen = 0;

    int          n, hs, snap;
    logic [15:0] tg;
    logic [19:0] f1, f2, f3, f4;

    always #5 clk = ~clk;

    ac97_frame_tx #(.DATA_W(20), .CLK_DIV(CLK_DIV)) dut (
        .clock_24M (clk),
        .reset_n   (reset_n),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .ready     (ready),
        .cmd_valid (cmd_valid),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .sdata_out (sdata_out),
        .sync      (sync)
    );

    ac97_frame_tx #(.DATA_W(20), .CLK_DIV(4)) dut4 (
        .clock_24M (clk),
        .reset_n   (reset_n),
        .pcm_left  (pcm4_left),
        .pcm_right (pcm4_right),
        .ready     (ready4),
        .cmd_valid (1'b0),
        .cmd_addr  (7'h00),
        .cmd_data  (16'h0000),
        .cmd_ready (cmd_ready4),
        .sdata_out (sdata4),
        .sync      (sync4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Time is counted in cycles since reset release; the bit on the wire
    // and the frame contents follow from that count by plain arithmetic.
    bit   m_on = 1'b0;
    int   m_cyc;
    bit   m_frame [256];
    logic m_sdata, m_sync;

    always @(negedge clk) begin
        bit          tk;
        int          pos;
        logic        e_ready;
        logic [95:0] hi;
        tk  = 1'b0;
        pos = 0;
        if (m_on) begin
            tk      = (m_cyc % CLK_DIV) == (CLK_DIV - 1);
            pos     = (m_cyc / CLK_DIV) % 256;
            e_ready = tk && (pos == 0);
            check("mdl_ready", ready, e_ready);
            check("mdl_cmd_ready", cmd_ready, e_ready && cmd_valid);
            check("mdl_sdata", sdata_out, m_sdata);
            check("mdl_sync", sync, m_sync);
        end
        if (!reset_n) begin
            m_on    = 1'b1;
            m_cyc   = 0;
            m_sdata = 1'b0;
            m_sync  = 1'b0;
        end else if (m_on) begin
            if (tk) begin
                if (pos == 0) begin
                    hi = {1'b1, cmd_valid, cmd_valid, 1'b1, 1'b1, 11'd0,
                          cmd_valid ? {1'b0, cmd_addr, 12'd0} : 20'd0,
                          cmd_valid ? {cmd_data, 4'd0} : 20'd0,
                          pcm_left, pcm_right};
                    for (int i = 0; i < 256; i++) begin
                        m_frame[i] = hi[95];
                        hi = {hi[94:0], 1'b0};
                    end
                end
                m_sdata = m_frame[pos];
                m_sync  = pos < 16;
            end
            m_cyc++;
        end
    end

    always @(negedge clk) if (cmd_ready === 1'b1) cmd_ready_seen++;

    function automatic logic [19:0] m_field(input int start, input int w);
        logic [19:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r = {r[18:0], m_frame[start + i]};
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic wait_ready(input bit d4, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(d4 ? ready4 : ready) && cnt < 2100);
        check("ready_arrives", d4 ? ready4 : ready, 1);
    endtask

    // Call at the ready negedge or #1 after the following posedge.
    task automatic grab(input bit d4, output logic [15:0] t,
                        output logic [19:0] s1, output logic [19:0] s2,
                        output logic [19:0] s3, output logic [19:0] s4);
        logic [95:0] v;
        v = '0;
        for (int i = 0; i < 96; i++) begin
            repeat (d4 ? 4 : 2) @(negedge clk);
            v = {v[94:0], d4 ? sdata4 : sdata_out};
        end
        {t, s1, s2, s3, s4} = v;
    endtask

    task automatic first_frames(input string tag_name);
        wait_ready(1'b0, n);
        check({tag_name, "_first_ready_cycle"}, n, 2);
        n  = 0;
        hs = 0;
        do begin
            @(negedge clk);
            n++;
            if (sync) hs++;
        end while (!ready && n < 2100);
        check({tag_name, "_ready_period"}, n, 512);
        check({tag_name, "_sync_cycles"}, hs, 32);
        grab(1'b0, tg, f1, f2, f3, f4);
        check({tag_name, "_tag"}, tg, 16'h9800);
        check({tag_name, "_slot1"}, f1, 20'h00000);
        check({tag_name, "_slot2"}, f2, 20'h00000);
        check({tag_name, "_slot3"}, f3, 20'h0C8BD);
        check({tag_name, "_slot4"}, f4, 20'hF3743);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n    = 1'b0;
        pcm_left   = 20'h0C8BD;
        pcm_right  = 20'hF3743;
        cmd_valid  = 1'b0;
        cmd_addr   = 7'h00;
        cmd_data   = 16'h0000;
        pcm4_left  = 20'h12345;
        pcm4_right = 20'hABCDE;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_sdata", sdata_out, 0);
        check("rst_sync", sync, 0);
        check("rst_ready", ready, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // reset to first frame
        first_frames("boot");
        check("model_pin_tag", m_field(0, 16), 20'h09800);
        check("model_pin_slot3", m_field(56, 20), 20'h0C8BD);

        // CLK_DIV = 4 build
        wait_ready(1'b1, n);
        check("div4_cmd_ready", cmd_ready4, 0);
        n  = 0;
        hs = 0;
        do begin
            @(negedge clk);
            n++;
            if (sync4) hs++;
        end while (!ready4 && n < 2100);
        check("div4_ready_period", n, 1024);
        check("div4_sync_cycles", hs, 64);
        grab(1'b1, tg, f1, f2, f3, f4);
        check("div4_tag", tg, 16'h9800);
        check("div4_slot3", f3, 20'h12345);
        check("div4_slot4", f4, 20'hABCDE);

        // command write
        @(posedge clk); #1;
        snap      = cmd_ready_seen;
        cmd_valid = 1'b1;
        cmd_addr  = 7'h02;
        cmd_data  = 16'h0808;
        wait_ready(1'b0, n);
        check("cmd_ready_with_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        grab(1'b0, tg, f1, f2, f3, f4);
        check("cmd_tag", tg, 16'hF800);
        check("cmd_slot1", f1, 20'h02000);
        check("cmd_slot2", f2, 20'h08080);
        check("cmd_ready_pulses", cmd_ready_seen - snap, 1);
        wait_ready(1'b0, n);
        grab(1'b0, tg, f1, f2, f3, f4);
        check("after_cmd_tag", tg, 16'h9800);
        check("after_cmd_slot1", f1, 20'h00000);

        // cmd_valid rising in the ready cycle
        wait_ready(1'b0, n);
        repeat (FRAME_CYC) @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_addr  = 7'h2C;
        cmd_data  = 16'h1234;
        @(negedge clk);
        check("same_cycle_ready", ready, 1);
        check("same_cycle_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        grab(1'b0, tg, f1, f2, f3, f4);
        check("same_cycle_tag", tg, 16'hF800);
        check("same_cycle_slot1", f1, 20'h2C000);
        check("same_cycle_slot2", f2, 20'h12340);

        // cmd_valid rising one cycle after ready waits a full frame
        wait_ready(1'b0, n);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 7'h18;
        cmd_data  = 16'hBEEF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 2100);
        check("late_cmd_wait", n, FRAME_CYC);
        check("late_cmd_ready", ready, 1);
        @(posedge clk); #1 cmd_valid = 1'b0;
        grab(1'b0, tg, f1, f2, f3, f4);
        check("late_cmd_tag", tg, 16'hF800);
        check("late_cmd_slot1", f1, 20'h18000);
        check("late_cmd_slot2", f2, 20'hBEEF0);

        // one frame of PCM latency
        wait_ready(1'b0, n);
        @(posedge clk); #1 pcm_left = 20'h7FFFF;
        grab(1'b0, tg, f1, f2, f3, f4);
        check("latency_old_slot3", f3, 20'h0C8BD);
        wait_ready(1'b0, n);
        grab(1'b0, tg, f1, f2, f3, f4);
        check("latency_new_slot3", f3, 20'h7FFFF);

        // reset while bit 60 is on the wire
        wait_ready(1'b0, n);
        repeat (60 * CLK_DIV + 1) @(posedge clk);
        #1;
        check("bit60_sdata", sdata_out, 1);
        check("bit60_sync", sync, 0);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_sdata", sdata_out, 0);
        check("midrst_sync", sync, 0);
        check("midrst_ready", ready, 0);
        pcm_left = 20'h0C8BD;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        first_frames("rerun");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
